mmio_mem_stage: RTL and testbench
=================================

MMIO_MEM_STAGE -- requirements
Module: mmio_mem_stage

Interface
REQ-001 SHALL have parameter DMEM_BASE, default 32'h1000_0000, byte base subtracted to form the data-memory offset.
REQ-002 SHALL have parameter MMIO_BASE, default 32'hFFFF_FF00, base of the 256-byte peripheral window.
REQ-003 SHALL have parameter UART_DEPTH, default 8, UART TX FIFO entries (power of 2, ≥2).
REQ-004 SHALL have parameter TIMER_W, default 64, cycle-counter width (33..64).
REQ-005 SHALL have ports, in order:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- result  in  32  ALU result / effective address
- op2_data  in  32  store data
- mem_write  in  1  store strobe
- mem_read  in  1  load strobe
- store_type  in  2  store size
- load_type  in  3  load size/sign
- calculated_result  out  32  result passthrough
- read_data  out  32  load data, 1 cycle after mem_read
- stall  out  1  pipeline hold request
- dmem_addr  out  32  result - DMEM_BASE
- dmem_wdata  out  32  op2_data
- dmem_wen  out  1  data-memory write enable
- dmem_size  out  3  load_type passthrough
- dmem_rdata  in  32  synchronous data-memory read data
- uart_tx_valid  out  1  FIFO head valid
- uart_tx_data  out  8  FIFO head byte
- uart_tx_ready  in  1  consumer accepts head
- timer_irq  out  1  compare-match interrupt, level

Function
REQ-006 SHALL decode MMIO offsets as result - MMIO_BASE when result ≥ MMIO_BASE: 0x00 TIME_LO (R), 0x04 TIME_HI (R), 0x08 CMP_LO (RW), 0x0C CMP_HI (RW), 0x10 IRQ_CLR (W, any value), 0xF8 UART_STAT (R), 0xFC UART_TX (W). All other accesses SHALL go to data memory.
REQ-007 SHALL assert dmem_wen = mem_write & ~mmio_hit; dmem_addr, dmem_wdata, dmem_size SHALL be combinational from the inputs.
REQ-008 SHALL drive calculated_result = result combinationally.
REQ-009 SHALL register the load select (dmem or MMIO register ID) and the MMIO read value on each mem_read edge, giving read_data one-cycle latency matching dmem_rdata; MMIO reads SHALL return full 32-bit words regardless of load_type.
REQ-010 SHALL run the timer counter incrementing by 1 every cycle and wrapping modulo 2^TIMER_W; TIME_HI SHALL return the zero-extended bits [TIMER_W-1:32].
REQ-011 SHALL latch TIME_HI into a shadow register on every TIME_LO read; a TIME_HI read SHALL return the shadow, so a LO-then-HI pair is coherent across a 32-bit carry.
REQ-012 SHALL set the timer_irq flag when counter == {CMP_HI,CMP_LO} (truncated to TIMER_W); the flag SHALL stay set until an IRQ_CLR write; a match and a clear in the same cycle SHALL leave the flag set.
REQ-013 SHALL reset the compare value to all ones so no interrupt fires before software programs it.
REQ-014 SHALL push op2_data[7:0] on a UART_TX write when the FIFO is not full.
REQ-015 SHALL assert stall combinationally on a UART_TX write while the FIFO is full, with no push; the push SHALL occur in the first cycle the FIFO is not full.
REQ-016 SHALL pop on uart_tx_valid & uart_tx_ready; uart_tx_valid SHALL equal ~empty.
REQ-017 SHALL allow a simultaneous push and pop when full; stall SHALL deassert in that cycle and the count SHALL remain UART_DEPTH.
REQ-018 SHALL use FIFO pointers wrapping modulo UART_DEPTH, with a count register of width clog2(UART_DEPTH)+1.
REQ-019 SHALL return UART_STAT = {23'b0, full, count[7:0]}, with count zero-extended to 8 bits.

Reset
REQ-020 SHALL, on rst, clear the counter, the shadow, the IRQ flag, the FIFO pointers and count, and the registered load select and data; read_data, stall, uart_tx_valid and timer_irq SHALL all be 0.
REQ-021 SHALL take effect asynchronously, discarding any FIFO contents mid-operation; release SHALL be synchronous to clk.

Structure
REQ-022 SHALL place the MMIO offset localparams and the load-select enum in the shared rv_mem_pkg package.
REQ-023 SHALL implement the UART FIFO as sub-module sync_fifo (parameters WIDTH, DEPTH; ports push, pop, din, dout, full, empty, count).

Verification
REQ-024 Store 0x12345678 to 0x1000_0010 -> dmem_wen=1, dmem_addr=0x10; no FIFO push.
REQ-025 9 UART_TX writes (bytes 0x41..0x49) with uart_tx_ready=0 -> stall high on the 9th write; after ready pulses 1 cycle, stall drops and the FIFO drains in order 0x41..0x49.
REQ-026 Counter forced to 0x0000_0000_FFFF_FFFF: read TIME_LO then TIME_HI -> returns 0xFFFF_FFFF then 0x0000_0000.
REQ-027 CMP = 20 after reset -> timer_irq rises on the counter==20 edge, stays high, and clears on the IRQ_CLR write; a clear coincident with a match -> flag remains 1.
REQ-028 FIFO full with push and pop together -> count stays 8, stall=0, data order preserved.
REQ-029 rst asserted with 3 FIFO entries pending -> uart_tx_valid=0 immediately and UART_STAT reads 0 after release.

Source files
------------

// File: rtl/rv_mem_pkg.sv
// Shared memory-stage definitions: MMIO register offsets within the peripheral
// window and the registered load-source selector.
package rv_mem_pkg;

  localparam logic [7:0] MMIO_TIME_LO   = 8'h00;
  localparam logic [7:0] MMIO_TIME_HI   = 8'h04;
  localparam logic [7:0] MMIO_CMP_LO    = 8'h08;
  localparam logic [7:0] MMIO_CMP_HI    = 8'h0C;
  localparam logic [7:0] MMIO_IRQ_CLR   = 8'h10;
  localparam logic [7:0] MMIO_UART_STAT = 8'hF8;
  localparam logic [7:0] MMIO_UART_TX   = 8'hFC;

  typedef enum logic [1:0] {
    LSEL_NONE = 2'd0,
    LSEL_DMEM = 2'd1,
    LSEL_MMIO = 2'd2
  } load_sel_e;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with power-of-two depth; a pop frees the slot so a push
// may land in the same cycle even when full.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             do_push, do_pop;

  assign empty   = (count_q == '0);
  assign full    = (count_q == FULL_CNT);
  assign count   = count_q;
  assign dout    = mem_q[rd_ptr_q];
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage carries data only, so it is left out of reset.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= din;
  end

endmodule

// File: rtl/mmio_mem_stage.sv
// Memory stage: routes loads/stores to data memory or to a small MMIO window
// holding a free-running timer with compare interrupt and a UART TX FIFO.
module mmio_mem_stage
  import rv_mem_pkg::*;
#(
  parameter logic [31:0] DMEM_BASE  = 32'h1000_0000,
  parameter logic [31:0] MMIO_BASE  = 32'hFFFF_FF00,
  parameter int          UART_DEPTH = 8,
  parameter int          TIMER_W    = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] result,
  input  logic [31:0] op2_data,
  input  logic        mem_write,
  input  logic        mem_read,
  input  logic [1:0]  store_type,
  input  logic [2:0]  load_type,
  output logic [31:0] calculated_result,
  output logic [31:0] read_data,
  output logic        stall,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  output logic        dmem_wen,
  output logic [2:0]  dmem_size,
  input  logic [31:0] dmem_rdata,
  output logic        uart_tx_valid,
  output logic [7:0]  uart_tx_data,
  input  logic        uart_tx_ready,
  output logic        timer_irq
);

  localparam int CW = $clog2(UART_DEPTH) + 1;

  logic [31:0] mmio_off;
  logic [7:0]  reg_id;
  logic        mmio_hit, mmio_wr, mmio_rd;

  assign mmio_off = result - MMIO_BASE;
  assign mmio_hit = (result >= MMIO_BASE) && (mmio_off[31:8] == 24'd0);
  assign reg_id   = mmio_off[7:0];
  assign mmio_wr  = mem_write & mmio_hit;
  assign mmio_rd  = mem_read & mmio_hit;

  assign calculated_result = result;
  assign dmem_addr         = result - DMEM_BASE;
  assign dmem_wdata        = op2_data;
  assign dmem_wen          = mem_write & ~mmio_hit;
  assign dmem_size         = load_type;

  // Sub-word store sizing is applied by the data memory itself.
  logic unused_store_type;
  assign unused_store_type = ^store_type;

  logic [TIMER_W-1:0] time_q, time_d;
  logic [63:0]        time_ext, cmp_ext;
  logic [31:0]        shadow_q, shadow_d;
  logic [31:0]        cmp_lo_q, cmp_lo_d, cmp_hi_q, cmp_hi_d;
  logic               irq_q, irq_d, cmp_match;

  assign time_ext  = 64'(time_q);
  assign cmp_ext   = {cmp_hi_q, cmp_lo_q};
  assign cmp_match = (time_q == cmp_ext[TIMER_W-1:0]);
  assign timer_irq = irq_q;

  logic            uart_wr, fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [7:0]      fifo_dout;
  logic [CW-1:0]   fifo_count;
  logic [31:0]     uart_stat;

  assign uart_wr       = mmio_wr && (reg_id == MMIO_UART_TX);
  assign fifo_pop      = ~fifo_empty & uart_tx_ready;
  // A pop in the same cycle frees a slot, so a write to a full FIFO proceeds.
  assign fifo_push     = uart_wr & (~fifo_full | fifo_pop);
  assign stall         = uart_wr & fifo_full & ~fifo_pop;
  assign uart_tx_valid = ~fifo_empty;
  assign uart_tx_data  = fifo_dout;
  assign uart_stat     = {23'd0, fifo_full, 8'(fifo_count)};

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (UART_DEPTH)
  ) u_uart_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .din   (op2_data[7:0]),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  logic [31:0] mmio_rval;
  load_sel_e   sel_q, sel_d;
  logic [31:0] rdata_q, rdata_d;

  always_comb begin
    mmio_rval = '0;
    case (reg_id)
      MMIO_TIME_LO:   mmio_rval = time_ext[31:0];
      MMIO_TIME_HI:   mmio_rval = shadow_q;
      MMIO_CMP_LO:    mmio_rval = cmp_lo_q;
      MMIO_CMP_HI:    mmio_rval = cmp_hi_q;
      MMIO_UART_STAT: mmio_rval = uart_stat;
      default:        mmio_rval = '0;
    endcase
  end

  always_comb begin
    time_d   = time_q + 1'b1;
    shadow_d = shadow_q;
    cmp_lo_d = cmp_lo_q;
    cmp_hi_d = cmp_hi_q;
    irq_d    = irq_q;
    sel_d    = sel_q;
    rdata_d  = rdata_q;
    // TIME_LO snapshots the high half so a following TIME_HI read is coherent.
    if (mmio_rd && reg_id == MMIO_TIME_LO) shadow_d = time_ext[63:32];
    if (mmio_wr && reg_id == MMIO_CMP_LO)  cmp_lo_d = op2_data;
    if (mmio_wr && reg_id == MMIO_CMP_HI)  cmp_hi_d = op2_data;
    if (mmio_wr && reg_id == MMIO_IRQ_CLR) irq_d = 1'b0;
    if (cmp_match)                         irq_d = 1'b1;
    if (mem_read) begin
      sel_d   = mmio_hit ? LSEL_MMIO : LSEL_DMEM;
      rdata_d = mmio_hit ? mmio_rval : '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      time_q   <= '0;
      shadow_q <= '0;
      cmp_lo_q <= '1;
      cmp_hi_q <= '1;
      irq_q    <= 1'b0;
      sel_q    <= LSEL_NONE;
      rdata_q  <= '0;
    end else begin
      time_q   <= time_d;
      shadow_q <= shadow_d;
      cmp_lo_q <= cmp_lo_d;
      cmp_hi_q <= cmp_hi_d;
      irq_q    <= irq_d;
      sel_q    <= sel_d;
      rdata_q  <= rdata_d;
    end
  end

  always_comb begin
    read_data = '0;
    case (sel_q)
      LSEL_DMEM: read_data = dmem_rdata;
      LSEL_MMIO: read_data = rdata_q;
      default:   read_data = '0;
    endcase
  end

endmodule

// File: tb/tb_mmio_mem_stage.sv
// Bench for mmio_mem_stage: decode vector table, directed timer/UART sequences
// and a randomized run against a queue-based FIFO and cycle-count timer model.
module tb_mmio_mem_stage;

  localparam int D = 8;
  localparam logic [31:0] MB = 32'hFFFF_FF00;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] result = '0, op2_data = '0, dmem_rdata = '0;
  logic        mem_write = 1'b0, mem_read = 1'b0, uart_tx_ready = 1'b0;
  logic [1:0]  store_type = '0;
  logic [2:0]  load_type = '0;
  logic [31:0] calculated_result, read_data, dmem_addr, dmem_wdata;
  logic        stall, dmem_wen, uart_tx_valid, timer_irq;
  logic [2:0]  dmem_size;
  logic [7:0]  uart_tx_data;

  mmio_mem_stage dut (
    .clk(clk), .rst(rst), .result(result), .op2_data(op2_data),
    .mem_write(mem_write), .mem_read(mem_read), .store_type(store_type),
    .load_type(load_type), .calculated_result(calculated_result),
    .read_data(read_data), .stall(stall), .dmem_addr(dmem_addr),
    .dmem_wdata(dmem_wdata), .dmem_wen(dmem_wen), .dmem_size(dmem_size),
    .dmem_rdata(dmem_rdata), .uart_tx_valid(uart_tx_valid),
    .uart_tx_data(uart_tx_data), .uart_tx_ready(uart_tx_ready),
    .timer_irq(timer_irq)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;
  logic [63:0] m_time = '0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One clock; the model counter follows the spec rule: cleared under reset, +1 otherwise.
  task automatic step();
    @(posedge clk);
    m_time = rst ? 64'd0 : m_time + 64'd1;
    @(negedge clk);
  endtask

  task automatic idle();
    mem_write = 1'b0; mem_read = 1'b0; result = '0; op2_data = '0;
    load_type = '0; store_type = '0;
  endtask

  task automatic mwr(input logic [7:0] off, input logic [31:0] data);
    idle(); result = MB + {24'd0, off}; op2_data = data; mem_write = 1'b1;
  endtask

  task automatic mrd(input logic [7:0] off);
    idle(); result = MB + {24'd0, off}; mem_read = 1'b1;
  endtask

  typedef struct {
    logic [31:0] res;
    logic [31:0] wd;
    logic        wr;
    logic [2:0]  lt;
    logic [31:0] exp_addr;
    logic        exp_wen;
  } dvec_t;

  dvec_t vecs[7];
  logic [7:0]  q[$];
  logic        hold, pend_v, exp_stall;
  logic [31:0] pend_e, pend_d;
  logic [7:0]  wb;
  logic [63:0] t_lo;
  int          op, guard;

  initial begin
    vecs[0] = '{32'h1000_0010, 32'h1234_5678, 1'b1, 3'd2, 32'h0000_0010, 1'b1};
    vecs[1] = '{32'h1000_0000, 32'h0000_0000, 1'b0, 3'd0, 32'h0000_0000, 1'b0};
    vecs[2] = '{32'h0FFF_FFFC, 32'h0000_00AA, 1'b1, 3'd4, 32'hFFFF_FFFC, 1'b1};
    vecs[3] = '{32'hFFFF_FF40, 32'hDEAD_BEEF, 1'b1, 3'd1, 32'hEFFF_FF40, 1'b0};
    vecs[4] = '{32'hFFFF_FEFC, 32'h0000_0055, 1'b1, 3'd5, 32'hEFFF_FEFC, 1'b1};
    vecs[5] = '{32'hFFFF_FFFF, 32'h0000_0001, 1'b1, 3'd3, 32'hEFFF_FFFF, 1'b0};
    vecs[6] = '{32'h0000_0000, 32'hCAFE_F00D, 1'b1, 3'd0, 32'hF000_0000, 1'b1};

    // Reset state
    idle();
    step(); step();
    check("rst_read_data", read_data, 0);
    check("rst_stall", stall, 0);
    check("rst_valid", uart_tx_valid, 0);
    check("rst_irq", timer_irq, 0);
    rst = 1'b0;

    // Compare defaults to all ones; program CMP=20 and watch the interrupt
    mrd(MMIO_CMP_HI_OFF()); step();
    mrd(8'h08);
    check("cmp_hi_rst", read_data, 32'hFFFF_FFFF); step();
    mwr(8'h08, 32'd20);
    check("cmp_lo_rst", read_data, 32'hFFFF_FFFF); step();
    mwr(8'h0C, 32'd0); step();
    mrd(8'h08); step(); idle();
    check("cmp_lo_rb", read_data, 32'd20);
    guard = 0;
    while (m_time < 64'd20 && guard < 100) begin step(); guard++; end
    check("irq_before_match", timer_irq, 0);
    step();
    check("irq_at_match", timer_irq, 1);
    step(); step(); step();
    check("irq_sticky", timer_irq, 1);
    mwr(8'h10, 32'h0); step(); idle();
    check("irq_cleared", timer_irq, 0);
    mwr(8'h08, 32'(m_time + 64'd3)); step(); idle();
    step();
    check("irq_pre_coincide", timer_irq, 0);
    step();
    mwr(8'h10, 32'h1); step(); idle();
    check("irq_clr_vs_match", timer_irq, 1);
    mwr(8'h10, 32'h0); step(); idle();
    check("irq_clr2", timer_irq, 0);

    // Data-memory decode table
    for (int i = 0; i < 7; i++) begin
      idle();
      result = vecs[i].res; op2_data = vecs[i].wd;
      mem_write = vecs[i].wr; load_type = vecs[i].lt;
      #1;
      check($sformatf("v%0d_wen", i), dmem_wen, vecs[i].exp_wen);
      check($sformatf("v%0d_addr", i), dmem_addr, vecs[i].exp_addr);
      check($sformatf("v%0d_wdata", i), dmem_wdata, vecs[i].wd);
      check($sformatf("v%0d_calc", i), calculated_result, vecs[i].res);
      check($sformatf("v%0d_size", i), dmem_size, vecs[i].lt);
      step();
      check($sformatf("v%0d_nopush", i), uart_tx_valid, 0);
    end

    // UART fill to full, stall, push+pop while full, then drain
    idle(); uart_tx_ready = 1'b0;
    for (int k = 0; k < 9; k++) begin
      mwr(8'hFC, 32'h41 + k);
      #1 check($sformatf("stall_fill%0d", k), stall, (k == 8));
      if (k < 8) step();
    end
    step();
    check("stall_held", stall, 1);
    check("head_held", uart_tx_data, 8'h41);
    uart_tx_ready = 1'b1;
    #1 check("stall_pushpop", stall, 0);
    check("head_pushpop", uart_tx_data, 8'h41);
    step();
    uart_tx_ready = 1'b0;
    mrd(8'hF8);
    #1 check("stall_after", stall, 0);
    step(); idle();
    check("stat_full", read_data, 32'h0000_0108);
    for (int k = 1; k <= 8; k++) begin
      check($sformatf("drain_valid%0d", k), uart_tx_valid, 1);
      check($sformatf("drain_data%0d", k), uart_tx_data, 8'(32'h41 + k));
      uart_tx_ready = 1'b1;
      step();
    end
    uart_tx_ready = 1'b0;
    check("drain_empty", uart_tx_valid, 0);

    // Timer carry coherence with the counter forced just below a 32-bit carry
    force dut.time_q = 64'h0000_0000_FFFF_FFFF;
    m_time = 64'h0000_0000_FFFF_FFFF;
    mrd(8'h00);
    #1 release dut.time_q;
    step();
    mrd(8'h04);
    check("time_lo_carry", read_data, 32'hFFFF_FFFF);
    step();
    t_lo = m_time;
    mrd(8'h00);
    check("time_hi_shadow", read_data, 32'h0);
    step();
    mrd(8'h04);
    check("time_lo_after", read_data, t_lo[31:0]);
    step(); idle();
    check("time_hi_after", read_data, 32'h1);

    // Randomized traffic against the reference model
    hold = 1'b0; pend_v = 1'b0; pend_e = '0; pend_d = '0; op = 0; wb = '0;
    for (int i = 0; i < 400; i++) begin
      if (!hold) begin
        op = $urandom_range(0, 5);
        wb = 8'($urandom);
      end
      uart_tx_ready = ($urandom_range(0, 9) < 3);
      dmem_rdata = pend_d;
      idle();
      case (op)
        0, 1: begin result = MB + 32'hFC; op2_data = {24'($urandom), wb}; mem_write = 1'b1; end
        2: begin result = MB + 32'hF8; mem_read = 1'b1; end
        3: begin result = MB; mem_read = 1'b1; end
        4: begin result = 32'h1000_0000 + ($urandom & 32'hFFFC); mem_read = 1'b1; end
        default: begin result = 32'h1000_0100; op2_data = $urandom; mem_write = 1'b1; end
      endcase
      #1;
      if (pend_v) check("rnd_read_data", read_data, pend_e);
      exp_stall = (op <= 1) && (q.size() == D) && !(uart_tx_ready && q.size() != 0);
      check("rnd_stall", stall, exp_stall);
      check("rnd_valid", uart_tx_valid, (q.size() != 0));
      if (q.size() != 0) check("rnd_data", uart_tx_data, q[0]);
      if (op == 5) check("rnd_wen", dmem_wen, 1);
      pend_v = (op >= 2 && op <= 4);
      if (op == 2) pend_e = {23'd0, (q.size() == D), 8'(q.size())};
      if (op == 3) pend_e = m_time[31:0];
      if (op == 4) begin pend_d = $urandom; pend_e = pend_d; end
      if (uart_tx_ready && q.size() != 0) void'(q.pop_front());
      if (op <= 1 && !exp_stall) q.push_back(wb);
      hold = exp_stall;
      step();
    end

    // Asynchronous reset with entries pending
    idle(); uart_tx_ready = 1'b1;
    for (int k = 0; k < D + 2; k++) step();
    uart_tx_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin mwr(8'hFC, 32'h60 + k); step(); end
    idle();
    check("pending_valid", uart_tx_valid, 1);
    #2 rst = 1'b1;
    #1 check("async_rst_valid", uart_tx_valid, 0);
    check("async_rst_rdata", read_data, 0);
    step();
    rst = 1'b0;
    mrd(8'hF8); step(); idle();
    check("stat_after_rst", read_data, 0);
    check("valid_after_rst", uart_tx_valid, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  function automatic logic [7:0] MMIO_CMP_HI_OFF();
    return 8'h0C;
  endfunction

endmodule
